// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one pipelined ALU between two requesters. One request is accepted
// at a time, its operands are driven onto the ALU, and after ALU_LAT
// register stages the result is returned to the requester that issued it.
// When both requesters are waiting, grants alternate between them.
//
// Parameters
//   ALU_LAT      ALU register stages between operands and result (0..7)
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   req0_*       requester 0: valid, operand a, operand b, opcode s
//   req1_*       requester 1: same as requester 0
//   req0_ready   one-cycle accept pulse to requester 0
//   req1_ready   one-cycle accept pulse to requester 1
//   resp0_valid  one-cycle result pulse to requester 0
//   resp1_valid  one-cycle result pulse to requester 1
//   resp_f       shared result bus, holds the last captured result
//   alu_a/b/s    operand and opcode drive to the ALU
//   alu_f        result from the ALU
//   busy         high whenever the arbiter is not idle
//   op_count     completed operations, wraps at 256
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_a,
    input  logic [1:0] req0_b,
    input  logic [2:0] req0_s,
    input  logic       req1_valid,
    input  logic [1:0] req1_a,
    input  logic [1:0] req1_b,
    input  logic [2:0] req1_s,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       resp0_valid,
    output logic       resp1_valid,
    output logic [3:0] resp_f,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [2:0] alu_s,
    input  logic [3:0] alu_f,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(ALU_LAT);

    state_t     state_q,      state_d;
    logic [2:0] cnt_q,        cnt_d;
    logic       owner_q,      owner_d;
    logic       last_q,       last_d;
    logic [1:0] alu_a_q,      alu_a_d;
    logic [1:0] alu_b_q,      alu_b_d;
    logic [2:0] alu_s_q,      alu_s_d;
    logic       req0_ready_q, req0_ready_d;
    logic       req1_ready_q, req1_ready_d;
    logic       resp0_q,      resp0_d;
    logic       resp1_q,      resp1_d;
    logic [3:0] resp_f_q,     resp_f_d;
    logic [7:0] op_count_q,   op_count_d;
    logic       busy_q,       busy_d;
    logic       grant;

    // Next-state logic. Everything that leaves the block is computed here as
    // a _d value and registered below, so every output is a flop.
    // Requester 1 wins when it is the only one asking, or when both ask and
    // requester 1 was not the previous winner.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_d       = last_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_s_d      = alu_s_q;
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
        resp0_d      = 1'b0;
        resp1_d      = 1'b0;
        resp_f_d     = resp_f_q;
        op_count_d   = op_count_q;
        grant        = req1_valid & (~req0_valid | ~last_q);

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (grant) begin
                        alu_a_d      = req1_a;
                        alu_b_d      = req1_b;
                        alu_s_d      = req1_s;
                        req1_ready_d = 1'b1;
                    end else begin
                        alu_a_d      = req0_a;
                        alu_b_d      = req0_b;
                        alu_s_d      = req0_s;
                        req0_ready_d = 1'b1;
                    end
                    owner_d = grant;
                    last_d  = grant;
                    cnt_d   = 3'd0;
                    state_d = BUSY;
                end
            end

            // Operands stay parked on the ALU while cnt walks through the
            // pipeline latency; the result is taken on the edge where cnt
            // has reached ALU_LAT.
            BUSY: begin
                if (cnt_q == LAT) begin
                    resp_f_d   = alu_f;
                    resp0_d    = ~owner_q;
                    resp1_d    = owner_q;
                    op_count_d = op_count_q + 8'd1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset drops any in-flight operation
    // without a response and re-arms the tie-break so requester 0 wins next.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            alu_a_q      <= 2'd0;
            alu_b_q      <= 2'd0;
            alu_s_q      <= 3'd0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            resp0_q      <= 1'b0;
            resp1_q      <= 1'b0;
            resp_f_q     <= 4'd0;
            op_count_q   <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_s_q      <= alu_s_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
            resp0_q      <= resp0_d;
            resp1_q      <= resp1_d;
            resp_f_q     <= resp_f_d;
            op_count_q   <= op_count_d;
            busy_q       <= busy_d;
        end
    end

    assign req0_ready  = req0_ready_q;
    assign req1_ready  = req1_ready_q;
    assign resp0_valid = resp0_q;
    assign resp1_valid = resp1_q;
    assign resp_f      = resp_f_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_s       = alu_s_q;
    assign busy        = busy_q;
    assign op_count    = op_count_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one `alu` instance (2-bit operands `a`/`b`, 3-bit select `s`, 4-bit result `f`, clocked on `clk`) between two requesters. It captures one request at a time and drives the ALU operand/select inputs. It waits the ALU's pipeline latency, then returns the 4-bit result to the requester that issued the operation. It sits between the ALU and its two client blocks and is the only block that drives the ALU inputs.

## Interface
- `ALU_LAT`, default 1, ALU register stages between operands and `f`; legal range 0..7.
- `clk`, input, 1, system clock; all logic on rising edge.
- `rst`, input, 1, synchronous active-high reset.
- `req0_valid`, input, 1, requester 0 has an operation pending; held until `req0_ready`.
- `req0_a`, input, 2, requester 0 operand a.
- `req0_b`, input, 2, requester 0 operand b.
- `req0_s`, input, 3, requester 0 opcode.
- `req1_valid`, `req1_a`, `req1_b`, `req1_s`, inputs, 1/2/2/3, same for requester 1.
- `req0_ready`, `req1_ready`, outputs, 1 each, one-cycle grant/accept pulse.
- `resp0_valid`, `resp1_valid`, outputs, 1 each, one-cycle result-valid pulse to the issuing requester.
- `resp_f`, output, 4, shared result bus; holds the last result until the next one is captured.
- `alu_a`, `alu_b`, `alu_s`, outputs, 2/2/3, drive ALU `a`, `b`, `s`.
- `alu_f`, input, 4, from ALU `f`.
- `busy`, output, 1, high whenever state is not IDLE.
- `op_count`, output, 8, count of completed operations; wraps.

## Operation
- States: IDLE, BUSY, DONE. All outputs are registered.
- IDLE, no valid: stay.
- IDLE, any valid: grant one requester.
  - Load `alu_a`/`alu_b`/`alu_s` from that requester.
  - Set the matching `reqN_ready` to 1 for the next cycle only.
  - Record `owner` and set `last` to the granted index.
  - Clear `cnt` and go to BUSY.
- Arbitration:
  - If only one requester is valid, grant it.
  - If both are valid, grant the index not equal to `last`.
  - `last` resets to 1, so requester 0 wins the first tie.
- BUSY:
  - `alu_*` held stable.
  - If `cnt != ALU_LAT`: `cnt <= cnt+1`.
  - If `cnt == ALU_LAT`:
    - `resp_f <= alu_f`.
    - `resp<owner>_valid <= 1`.
    - `op_count <= op_count+1` (mod 256).
    - Go to DONE.
- DONE: lasts one cycle. The response pulse is visible in this cycle. Go to IDLE.
- The arbiter does not check opcodes; every `s` value 000..111 is passed through unchanged.
- Requesters must drop or replace `valid` in the cycle after seeing `ready`. The arbiter does not sample `valid` outside IDLE, so a stale `valid` during BUSY/DONE is ignored.
- Reset (any state, including mid-BUSY):
  - Next state is IDLE.
  - `alu_a`, `alu_b`, `alu_s`, `resp_f`, `op_count` = 0.
  - All ready and resp-valid outputs = 0; `busy` = 0.
  - `cnt` = 0, `last` = 1.
  - An in-flight operation is dropped with no response; the requester re-presents it.

## Timing
- Capture edge E0: IDLE with valid sampled.
- Cycle 1 (after E0): `reqN_ready` = 1, `busy` = 1, `alu_*` = captured operands.
- The ALU sees operands from cycle 1. `alu_f` is sampled at edge E(ALU_LAT+1).
- `respN_valid` and the new `resp_f` appear in cycle ALU_LAT+2. State returns to IDLE in cycle ALU_LAT+3.
- Earliest next capture is edge E(ALU_LAT+3), giving one operation per ALU_LAT+3 cycles.
- `resp_f` changes only at result capture or reset.

## Test plan
Bench drives `alu_f` from a stub computing f = a + b (zero-extended), delayed through ALU_LAT registers.
- ALU_LAT=1; req0 a=2, b=1, s=000 valid at E0 -> `req0_ready` in cycle 1; `alu_a`=2, `alu_b`=1, `alu_s`=0 held for cycles 1-2; `resp0_valid` in cycle 3 only; `resp_f`=3; `op_count`=1; `resp1_valid` never asserted.
- After reset, both valid and held (req0 a=1, b=1; req1 a=3, b=2) -> req0 granted first (`resp_f`=2 on `resp0_valid`), then req1 (`resp_f`=5 on `resp1_valid`), next grant starting 4 cycles after the first; with both still valid, grants alternate 0,1,0,1.
- `rst` pulsed during a BUSY cycle -> next cycle all outputs 0, `busy`=0, no resp-valid pulse ever for the dropped operation; next tie grants req0.
- ALU_LAT=0 and ALU_LAT=3, req1 a=3, b=3, s=111 -> `alu_s`=7 passed through; `resp_f`=6; `resp1_valid` in cycle 2 and cycle 5 after capture respectively.
- 256 back-to-back completions from req0 -> `op_count` reads 255, then 0, with no glitch on the other outputs.
